vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//   Generates VGA raster timing and the pixel coordinates consumed by the bar display
//   colour logic. Divides fsm_clk into a pixel tick and runs horizontal/vertical counters.
//   Drives x_coord/y_coord, hsync/vsync, video_on and frame_start, all aligned to the same edge.
//   Sits between the board clock and the bar display; RGB from the bar display is valid only when video_on=1.
// PARAMETERS
//   CLK_DIV   2    fsm_clk cycles per pixel (2: 50 MHz -> 25 MHz); >=1
//   H_ACTIVE  640  visible pixels per line
//   H_FP      16   horizontal front porch (pixels)
//   H_SYNC    96   hsync pulse width (pixels)
//   H_BP      48   horizontal back porch (pixels)
//   V_ACTIVE  480  visible lines per frame
//   V_FP      10   vertical front porch (lines)
//   V_SYNC    2    vsync pulse width (lines)
//   V_BP      33   vertical back porch (lines)
// PORTS
//   fsm_clk     in   1   system clock
//   rst_n       in   1   asynchronous reset, active low
//   enable      in   1   1 = raster runs; 0 = freeze all state
//   pix_tick    out  1   1-cycle strobe, once per CLK_DIV fsm_clk cycles
//   x_coord     out  10  horizontal count, 0..H_TOTAL-1
//   y_coord     out  10  vertical count, 0..V_TOTAL-1
//   hsync       out  1   horizontal sync, active low
//   vsync       out  1   vertical sync, active low
//   video_on    out  1   1 when x_coord<H_ACTIVE and y_coord<V_ACTIVE
//   frame_start out  1   1-cycle pulse when outputs load (0,0)
// BEHAVIOUR
//   - Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
//     Both totals must be <=1024; the counters are 10 bits.
//   - Reset: rst_n=0 clears the divider and both counters asynchronously.
//     Output reset values: pix_tick=0, x=0, y=0, hsync=1, vsync=1, video_on=0, frame_start=0.
//   - Divider: counts 0..CLK_DIV-1 while enable=1.
//     pix_tick=1 on the cycle the divider equals CLK_DIV-1; the divider then wraps to 0.
//     With CLK_DIV=1, pix_tick=1 on every enabled cycle.
//   - Counters: h and v advance only on cycles where pix_tick=1.
//     h wraps H_TOTAL-1 -> 0; v increments only on that h wrap.
//     v wraps V_TOTAL-1 -> 0 when h also wraps.
//   - Output stage: on each pix_tick cycle, one register stage loads x/y and the decodes
//     of the current (h,v); the counters step on the same edge.
//     All outputs therefore change together, one fsm_clk after the tick, and hold between ticks.
//     hsync=0 for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
//     vsync=0 for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491).
//     frame_start=1 for exactly one fsm_clk, when the load is (h,v)=(0,0); otherwise 0.
//   - enable=0: divider, counters and outputs hold; pix_tick=0; frame_start=0.
//     Re-enabling resumes the sequence without skipping or repeating a pixel.
//   - Reset mid-frame: outputs return to their reset values immediately, with no clock edge.
//     After release, the first pix_tick occurs at fsm_clk cycle CLK_DIV.
//     The following edge loads (0,0) with frame_start=1 and video_on=1.
//   - x_coord/y_coord also count through blanking; consumers gate on video_on.
// TESTING
//   1. Release rst_n, enable=1, CLK_DIV=2 -> pix_tick on cycle 2; next edge x=0, y=0,
//      video_on=1, frame_start=1; frame_start=0 one cycle later.
//   2. One full line -> x steps 0..799 then back to 0, y increments once.
//      hsync low exactly 96 ticks (192 fsm_clk), asserted when x=656, deasserted when x=752.
//      video_on falls when x=640.
//   3. Full frame -> vsync low for y=490..491 (1600 ticks).
//      frame_start period 420000 ticks = 840000 fsm_clk; y wraps 524 -> 0.
//   4. Drop enable at x=300 for 50 cycles -> all outputs frozen, pix_tick=0;
//      after re-enable the next load is x=301.
//   5. Assert rst_n=0 mid-frame at y=200 between clock edges -> outputs go to reset values
//      immediately; after release the test 1 sequence repeats.
//   6. CLK_DIV=1 build -> pix_tick constantly 1; hsync low exactly 96 consecutive fsm_clk.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: fsm_clk divider to a pixel tick, h/v counters and one registered output stage.
// Outputs change together one fsm_clk after each pix_tick; enable=0 freezes all state (no backpressure).
module vga_timing_gen #(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       fsm_clk,
   input  logic       rst_n,
   input  logic       enable,
   output logic       pix_tick,
   output logic [9:0] x_coord,
   output logic [9:0] y_coord,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0]  H_VIS  = 10'(H_ACTIVE);
   localparam logic [9:0]  V_VIS  = 10'(V_ACTIVE);
   localparam logic [9:0]  HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
   // Sync ends are 11 bits so a pulse running to the last count of a 1024 total still compares correctly.
   localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [DIV_W-1:0] div_q, div_d;
   logic [9:0]       h_q, h_d;
   logic [9:0]       v_q, v_d;
   logic             tick;

   logic [9:0]       x_q, x_d;
   logic [9:0]       y_q, y_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             video_q, video_d;
   logic             frame_q, frame_d;

   always_comb begin
      tick  = enable && (div_q == DIV_LAST);
      div_d = div_q;
      h_d   = h_q;
      v_d   = v_q;
      if (enable) begin
         div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      end
      if (tick) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
         end else begin
            h_d = h_q + 10'd1;
         end
      end
   end

   // Output stage samples the counters before they step on the same edge.
   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      video_d = video_q;
      frame_d = 1'b0;
      if (tick) begin
         x_d     = h_q;
         y_d     = v_q;
         hsync_d = !((h_q >= HS_BEG) && ({1'b0, h_q} < HS_END));
         vsync_d = !((v_q >= VS_BEG) && ({1'b0, v_q} < VS_END));
         video_d = (h_q < H_VIS) && (v_q < V_VIS);
         frame_d = (h_q == 10'd0) && (v_q == 10'd0);
      end
   end

   always_ff @(posedge fsm_clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
         h_q   <= '0;
         v_q   <= '0;
      end else begin
         div_q <= div_d;
         h_q   <= h_d;
         v_q   <= v_d;
      end
   end

   always_ff @(posedge fsm_clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q     <= '0;
         y_q     <= '0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         video_q <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         video_q <= video_d;
         frame_q <= frame_d;
      end
   end

   // Gated by reset so the strobe is low while held in reset, even with CLK_DIV=1.
   assign pix_tick    = tick && rst_n;
   assign x_coord     = x_q;
   assign y_coord     = y_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_q;
   assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size raster (CLK_DIV=2 and 1) plus a reduced raster for whole-frame timing.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, en0, en1, en2;

   logic       d0_tick, d0_hs, d0_vs, d0_vid, d0_fs;
   logic [9:0] d0_x, d0_y;
   logic       d1_tick, d1_hs, d1_vs, d1_vid, d1_fs;
   logic [9:0] d1_x, d1_y;
   logic       d2_tick, d2_hs, d2_vs, d2_vid, d2_fs;
   logic [9:0] d2_x, d2_y;

   int vectors     = 0;
   int miscompares = 0;

   vga_timing_gen u_dut (
      .fsm_clk(clk), .rst_n(rst_n), .enable(en0), .pix_tick(d0_tick),
      .x_coord(d0_x), .y_coord(d0_y), .hsync(d0_hs), .vsync(d0_vs),
      .video_on(d0_vid), .frame_start(d0_fs)
   );

   vga_timing_gen #(.CLK_DIV(1)) u_div1 (
      .fsm_clk(clk), .rst_n(rst_n), .enable(en1), .pix_tick(d1_tick),
      .x_coord(d1_x), .y_coord(d1_y), .hsync(d1_hs), .vsync(d1_vs),
      .video_on(d1_vid), .frame_start(d1_fs)
   );

   // Reduced raster: H_TOTAL=15 (sync at h=10..12), V_TOTAL=10 (sync at v=7..8).
   vga_timing_gen #(
      .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) u_small (
      .fsm_clk(clk), .rst_n(rst_n), .enable(en2), .pix_tick(d2_tick),
      .x_coord(d2_x), .y_coord(d2_y), .hsync(d2_hs), .vsync(d2_vs),
      .video_on(d2_vid), .frame_start(d2_fs)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rst(input string n, input logic t, input logic [9:0] x, input logic [9:0] y,
                          input logic hs, input logic vs, input logic vid, input logic fs);
      chk({n, "_tick"}, t, 0);
      chk({n, "_x"}, x, 0);
      chk({n, "_y"}, y, 0);
      chk({n, "_hsync"}, hs, 1);
      chk({n, "_vsync"}, vs, 1);
      chk({n, "_video"}, vid, 0);
      chk({n, "_fstart"}, fs, 0);
   endtask

   task automatic chk_load00(input string n, input logic t, input logic [9:0] x, input logic [9:0] y,
                             input logic hs, input logic vs, input logic vid, input logic fs);
      chk({n, "_tick"}, t, 0);
      chk({n, "_x"}, x, 0);
      chk({n, "_y"}, y, 0);
      chk({n, "_hsync"}, hs, 1);
      chk({n, "_vsync"}, vs, 1);
      chk({n, "_video"}, vid, 1);
      chk({n, "_fstart"}, fs, 1);
   endtask

   initial begin
      int hs_lo, x_fall, x_rise, x_vfall, x_max, bad, ok, zeros, run, run_len, period;
      int vs_lo, y_vfall, y_vrise, y_max, y_before;
      logic [9:0] px, y_w, py;
      logic phs, pvid, pvs;
      bit wrapped, done;

      rst_n = 1'b0; en0 = 1'b1; en1 = 1'b1; en2 = 1'b1;
      repeat (3) @(negedge clk);
      chk_rst("rst_d0", d0_tick, d0_x, d0_y, d0_hs, d0_vs, d0_vid, d0_fs);
      chk("rst_d1_tick", d1_tick, 0);

      // Release between edges: the divider needs CLK_DIV edges before the (0,0) load.
      rst_n = 1'b1;
      #1;
      chk("rel_c1_d0_tick", d0_tick, 0);
      chk("rel_c1_d1_tick", d1_tick, 1);
      @(negedge clk);
      chk("rel_c2_d0_tick", d0_tick, 1);
      chk("rel_c2_d0_fstart", d0_fs, 0);
      chk("rel_c2_d0_video", d0_vid, 0);
      chk("rel_c2_d1_fstart", d1_fs, 1);
      @(negedge clk);
      chk_load00("load_d0", d0_tick, d0_x, d0_y, d0_hs, d0_vs, d0_vid, d0_fs);
      chk("load_d1_fstart_gone", d1_fs, 0);
      @(negedge clk);
      chk("post_d0_fstart", d0_fs, 0);
      chk("post_d0_tick", d0_tick, 1);
      chk("post_d0_x_held", d0_x, 0);
      @(negedge clk);
      chk("post_d0_x_step", d0_x, 1);

      // One full line on the 800x525 raster.
      hs_lo = 0; x_fall = -1; x_rise = -1; x_vfall = -1; x_max = 0; bad = 0; wrapped = 0;
      px = d0_x; phs = d0_hs; pvid = d0_vid; y_w = '1;
      for (int i = 0; i < 1700 && !wrapped; i++) begin
         @(negedge clk);
         if (!d0_hs) hs_lo++;
         if (phs && !d0_hs) x_fall = d0_x;
         if (!phs && d0_hs) x_rise = d0_x;
         if (pvid && !d0_vid) x_vfall = d0_x;
         if (d0_x > x_max) x_max = d0_x;
         if (d0_x != px && d0_x != px + 10'd1 && d0_x != 10'd0) bad++;
         if (px != 10'd0 && d0_x == 10'd0) begin wrapped = 1; y_w = d0_y; end
         px = d0_x; phs = d0_hs; pvid = d0_vid;
      end
      chk("line_wrapped", wrapped, 1);
      chk("line_hsync_low_clks", hs_lo, 192);
      chk("line_hsync_fall_x", x_fall, 656);
      chk("line_hsync_rise_x", x_rise, 752);
      chk("line_video_fall_x", x_vfall, 640);
      chk("line_x_max", x_max, 799);
      chk("line_x_bad_steps", bad, 0);
      chk("line_y_after_wrap", y_w, 1);

      // Freeze at x=300 while the divider is mid-period.
      ok = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (d0_x == 10'd300) begin ok = 1; break; end
      end
      chk("wait_x300", ok, 1);
      @(negedge clk);
      chk("frz_pre_tick", d0_tick, 1);
      en0 = 1'b0;
      #1;
      chk("frz_tick_drop", d0_tick, 0);
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (d0_x != 10'd300 || d0_y != 10'd1 || d0_tick || d0_fs || !d0_vid || !d0_hs) bad++;
      end
      chk("frz_bad_cycles", bad, 0);
      chk("frz_x", d0_x, 300);
      en0 = 1'b1;
      #1;
      chk("frz_resume_tick", d0_tick, 1);
      @(negedge clk);
      chk("frz_next_x", d0_x, 301);
      chk("frz_next_tick", d0_tick, 0);

      // Whole frame on the reduced raster: 15*10 ticks = 300 fsm_clk.
      ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (d2_fs) begin ok = 1; break; end
      end
      chk("wait_small_fs", ok, 1);
      chk("small_fs_y", d2_y, 0);
      vs_lo = 0; y_vfall = -1; y_vrise = -1; y_max = 0; period = -1; y_before = -1;
      pvs = d2_vs; py = d2_y;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clk);
         if (!d2_vs) vs_lo++;
         if (pvs && !d2_vs) y_vfall = d2_y;
         if (!pvs && d2_vs) y_vrise = d2_y;
         if (d2_y > y_max) y_max = d2_y;
         if (d2_fs) begin period = i; y_before = py; break; end
         pvs = d2_vs; py = d2_y;
      end
      chk("frame_period_clks", period, 300);
      chk("frame_vsync_low_clks", vs_lo, 60);
      chk("frame_vsync_fall_y", y_vfall, 7);
      chk("frame_vsync_rise_y", y_vrise, 9);
      chk("frame_y_max", y_max, 9);
      chk("frame_y_wrap_from", y_before, 9);
      chk("frame_y_wrap_to", d2_y, 0);
      chk("frame_video_at_fs", d2_vid, 1);

      // CLK_DIV=1: tick every cycle, hsync low for exactly 96 consecutive clocks.
      zeros = 0; run = 0; run_len = -1; x_fall = -1; x_rise = -1; done = 0; phs = d1_hs;
      for (int i = 0; i < 1700 && !done; i++) begin
         @(negedge clk);
         if (!d1_tick) zeros++;
         if (phs && !d1_hs) begin run = 1; x_fall = d1_x; end
         else if (!d1_hs && run > 0) run++;
         if (!phs && d1_hs && run > 0) begin run_len = run; x_rise = d1_x; done = 1; end
         phs = d1_hs;
      end
      chk("div1_tick_zeros", zeros, 0);
      chk("div1_hsync_run", run_len, 96);
      chk("div1_hsync_fall_x", x_fall, 656);
      chk("div1_hsync_rise_x", x_rise, 752);

      // Asynchronous reset mid-frame, between clock edges.
      ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (d2_y == 10'd3) begin ok = 1; break; end
      end
      chk("wait_small_y3", ok, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_rst("arst_d2", d2_tick, d2_x, d2_y, d2_hs, d2_vs, d2_vid, d2_fs);
      chk_rst("arst_d0", d0_tick, d0_x, d0_y, d0_hs, d0_vs, d0_vid, d0_fs);
      chk("arst_d1_tick", d1_tick, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel2_c1_d0_tick", d0_tick, 0);
      @(negedge clk);
      chk("rel2_c2_d0_tick", d0_tick, 1);
      chk("rel2_c2_d2_tick", d2_tick, 1);
      @(negedge clk);
      chk_load00("rel2_load_d0", d0_tick, d0_x, d0_y, d0_hs, d0_vs, d0_vid, d0_fs);
      chk_load00("rel2_load_d2", d2_tick, d2_x, d2_y, d2_hs, d2_vs, d2_vid, d2_fs);
      @(negedge clk);
      chk("rel2_post_d0_fstart", d0_fs, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
